action_decoder: RTL and testbench
=================================

ACTION_DECODER -- requirements
Module: action_decoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50_000: consecutive stable cycles needed to accept a button level change.
REQ-002 SHALL have parameter COOLDOWN_CYCLES, default 24'd10_000_000: idle cycles enforced after each accepted action.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port buttons, input, 8: raw, asynchronous user switches. Only [5:0] are used; [7:6] are ignored.
REQ-006 SHALL have port act_ready, input, 1: the downstream stats stage accepts the offered action.
REQ-007 SHALL have port act_valid, output, 1: an action is offered.
REQ-008 SHALL have port act_code, output, 3: action index. 0 feed, 1 play, 2 heal, 3 clean, 4 sleep, 5 socialize.
REQ-009 SHALL have port busy, output, 1: cooldown in progress.
REQ-010 SHALL have port pressed, output, 6: debounced button levels.

Function
REQ-011 SHALL pass each buttons[5:0] bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL keep a per-bit debounce counter that:
- clears whenever the synced bit equals pressed[i];
- otherwise increments;
- on reaching DEBOUNCE_CYCLES, toggles pressed[i] and clears.
REQ-013 SHALL set pending[i] (6-bit register) on the edge where pressed[i] toggles 0->1. Release (1->0) SHALL set nothing.
REQ-014 SHALL saturate pending[i]: repeated presses before service are not queued twice.
REQ-015 SHALL implement FSM states IDLE, OFFER, COOLDOWN:
- IDLE->OFFER when pending != 0;
- OFFER->COOLDOWN on act_valid && act_ready;
- COOLDOWN->IDLE when the cooldown counter reaches 0.
REQ-016 On IDLE->OFFER, SHALL:
- load act_code with the lowest set pending index (fixed priority, 0 highest);
- clear that pending bit;
- assert act_valid on the next edge.
REQ-017 SHALL hold act_valid high and act_code stable while in OFFER until the handshake; act_valid SHALL NOT depend combinationally on act_ready.
REQ-018 On handshake, SHALL deassert act_valid the next cycle and load the cooldown counter with COOLDOWN_CYCLES.
REQ-019 busy SHALL equal (state == COOLDOWN). The counter SHALL decrement once per cycle and SHALL NOT wrap below 0.
REQ-020 If COOLDOWN_CYCLES == 0, the handshake SHALL go directly OFFER->IDLE; busy SHALL stay 0.
REQ-021 If the pending bit being cleared by issue is set again by a new press in the same cycle, the set SHALL win.
REQ-022 Presses arriving during OFFER or COOLDOWN SHALL accumulate in pending and be served in priority order afterwards.
REQ-023 Latency: with FSM IDLE and pending = 0, act_valid SHALL first be high after exactly DEBOUNCE_CYCLES+3 rising edges, counted from the first edge sampling buttons[i] high.
REQ-024 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL produce no change in pressed and no action.

Reset
REQ-025 While reset is high, SHALL immediately hold:
- act_valid = 0, act_code = 0, busy = 0, pressed = 0;
- pending = 0, all counters = 0, synchronizers = 0;
- state IDLE.
REQ-026 Reset asserted during OFFER SHALL drop act_valid asynchronously and discard the offer; no action SHALL be re-offered after release.
REQ-027 A button held high through reset deassertion SHALL be treated as a new press: one action after DEBOUNCE_CYCLES+3 edges.

Verification (DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8)
REQ-028 SHALL cover a single press: buttons=8'h04 held, act_ready=1 -> act_valid high after 7 edges for exactly 1 cycle with act_code=2, then busy=1 for 8 cycles, then 0.
REQ-029 SHALL cover glitch rejection: buttons[0] high for 3 cycles, then low -> pressed stays 0, act_valid never asserts.
REQ-030 SHALL cover backpressure: press button 1 with act_ready=0 for 20 cycles, then 1 -> act_valid held 20+ cycles, act_code=1 stable, exactly one handshake.
REQ-031 SHALL cover simultaneous presses: buttons=8'h21 held -> act_code=0 offered first; act_code=5 offered after cooldown; exactly two actions.
REQ-032 SHALL cover ignored bits: buttons=8'hC0 -> no pressed change, no action.
REQ-033 SHALL cover mid-offer reset: reset pulsed while act_valid=1 -> act_valid=0 in the same cycle, all outputs 0; with buttons released, no further action.

Source files
------------

// File: rtl/action_decoder_if.sv
// Button/action bus between the user switch bank, the decoder and the stats stage.
// The slave modport is the decoder's view; master is the driving environment.
interface action_decoder_if;
  logic [7:0] buttons;
  logic       act_ready;
  logic       act_valid;
  logic [2:0] act_code;
  logic       busy;
  logic [5:0] pressed;

  modport slave  (input buttons, act_ready, output act_valid, act_code, busy, pressed);
  modport master (output buttons, act_ready, input act_valid, act_code, busy, pressed);
endinterface

// File: rtl/action_decoder.sv
// Debounces six user buttons, latches presses as pending requests and offers them
// one at a time over a valid/ready handshake, followed by a cooldown window.
module debounce_lane #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic pressed_o,
  output logic rise_o
);
  logic [1:0]  sync_q;
  logic [15:0] cnt_q, cnt_d;
  logic        pressed_q, pressed_d;

  always_comb begin
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    if (sync_q[1] == pressed_q) begin
      cnt_d = '0;
    end else if ({1'b0, cnt_q} + 17'd1 >= {1'b0, DEBOUNCE_CYCLES}) begin
      pressed_d = ~pressed_q;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], raw_i};
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

  assign pressed_o = pressed_q;
  // Pending is registered on the same edge the debounced level rises.
  assign rise_o    = pressed_d & ~pressed_q;
endmodule

module action_decoder #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
  parameter logic [23:0] COOLDOWN_CYCLES = 24'd10_000_000
) (
  input  logic              clk,
  input  logic              reset,
  action_decoder_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, OFFER, COOLDOWN} state_e;

  state_e      state_q, state_d;
  logic [5:0]  pending_q, pending_d;
  logic [2:0]  code_q, code_d;
  logic [23:0] cool_q, cool_d;
  logic [5:0]  pressed, rise, clr_mask;
  logic [2:0]  sel;
  logic        unused_hi;

  assign unused_hi = ^bus.buttons[7:6];

  for (genvar g = 0; g < 6; g++) begin : g_lane
    debounce_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .raw_i     (bus.buttons[g]),
      .pressed_o (pressed[g]),
      .rise_o    (rise[g])
    );
  end

  // Fixed priority: lowest set index wins.
  always_comb begin
    sel = 3'd0;
    for (int i = 5; i >= 0; i--)
      if (pending_q[i]) sel = 3'(i);
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    cool_d   = cool_q;
    clr_mask = '0;
    unique case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d  = OFFER;
          code_d   = sel;
          clr_mask = 6'b1 << sel;
        end
      end
      OFFER: begin
        if (bus.act_ready) begin
          if (COOLDOWN_CYCLES == 24'd0) begin
            state_d = IDLE;
          end else begin
            state_d = COOLDOWN;
            cool_d  = COOLDOWN_CYCLES;
          end
        end
      end
      COOLDOWN: begin
        if (cool_q != 24'd0) cool_d = cool_q - 24'd1;
        if (cool_q <= 24'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh press beats the clear of the bit being issued.
    pending_d = (pending_q & ~clr_mask) | rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      cool_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      cool_q    <= cool_d;
    end
  end

  assign bus.act_valid = (state_q == OFFER);
  assign bus.act_code  = code_q;
  assign bus.busy      = (state_q == COOLDOWN);
  assign bus.pressed   = pressed;
endmodule

// File: tb/tb_action_decoder.sv
// Directed bench for action_decoder with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=8.
module tb_action_decoder;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   fails = 0;
  int   hs_cnt = 0;
  int   v_cnt = 0;

  action_decoder_if bus();

  action_decoder #(.DEBOUNCE_CYCLES(16'd4), .COOLDOWN_CYCLES(24'd8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && bus.act_valid) v_cnt++;
    if (!reset && bus.act_valid && bus.act_ready) hs_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until act_valid is seen at a negedge, bounded.
  task automatic wait_valid(input int bound, output int k);
    k = 0;
    while (!bus.act_valid && k < bound) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int k, nb, hs0, v0, good;
  logic [5:0] pr_seen;

  initial begin
    reset = 1'b1;
    bus.buttons = 8'h00;
    bus.act_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.act_valid), 32'd0);
    chk("rst_code", 32'(bus.act_code), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pressed", 32'(bus.pressed), 32'd0);
    idle(3);
    reset = 1'b0;
    idle(3);

    // Single press: 7-edge latency, one-cycle offer, 8 busy cycles.
    hs0 = hs_cnt;
    bus.buttons = 8'h04;
    wait_valid(20, k);
    chk("single_latency", 32'(k), 32'd7);
    chk("single_code", 32'(bus.act_code), 32'd2);
    chk("single_pressed", 32'(bus.pressed), 32'h04);
    @(negedge clk);
    chk("single_valid_drop", 32'(bus.act_valid), 32'd0);
    nb = 0;
    while (bus.busy && nb < 20) begin
      nb++;
      @(negedge clk);
    end
    chk("single_busy_len", 32'(nb), 32'd8);
    chk("single_after_busy", 32'(bus.busy), 32'd0);
    bus.buttons = 8'h00;
    idle(15);
    chk("single_hs", 32'(hs_cnt - hs0), 32'd1);
    chk("single_release", 32'(bus.pressed), 32'd0);

    // Glitch of 3 cycles is rejected.
    hs0 = hs_cnt; v0 = v_cnt; pr_seen = '0;
    bus.buttons = 8'h01;
    repeat (3) begin @(negedge clk); pr_seen |= bus.pressed; end
    bus.buttons = 8'h00;
    repeat (20) begin @(negedge clk); pr_seen |= bus.pressed; end
    chk("glitch_pressed", 32'(pr_seen), 32'd0);
    chk("glitch_valid", 32'(v_cnt - v0), 32'd0);

    // Backpressure: offer held with stable code until ready.
    hs0 = hs_cnt;
    bus.act_ready = 1'b0;
    bus.buttons = 8'h02;
    wait_valid(20, k);
    chk("bp_valid", 32'(bus.act_valid), 32'd1);
    good = 0;
    repeat (20) begin
      if (bus.act_valid && bus.act_code == 3'd1) good++;
      @(negedge clk);
    end
    chk("bp_hold", 32'(good), 32'd20);
    bus.act_ready = 1'b1;
    @(negedge clk);
    chk("bp_drop", 32'(bus.act_valid), 32'd0);
    bus.buttons = 8'h00;
    idle(25);
    chk("bp_hs", 32'(hs_cnt - hs0), 32'd1);

    // Simultaneous presses served in priority order.
    hs0 = hs_cnt;
    bus.buttons = 8'h21;
    wait_valid(20, k);
    chk("sim_first", 32'(bus.act_code), 32'd0);
    @(negedge clk);
    wait_valid(40, k);
    chk("sim_second_valid", 32'(bus.act_valid), 32'd1);
    chk("sim_second", 32'(bus.act_code), 32'd5);
    bus.buttons = 8'h00;
    idle(40);
    chk("sim_hs", 32'(hs_cnt - hs0), 32'd2);

    // Bits [7:6] are ignored.
    v0 = v_cnt; pr_seen = '0;
    bus.buttons = 8'hC0;
    repeat (30) begin @(negedge clk); pr_seen |= bus.pressed; end
    bus.buttons = 8'h00;
    chk("ign_pressed", 32'(pr_seen), 32'd0);
    chk("ign_valid", 32'(v_cnt - v0), 32'd0);

    // Reset mid-offer drops everything immediately.
    bus.act_ready = 1'b0;
    bus.buttons = 8'h08;
    wait_valid(20, k);
    chk("mr_valid_before", 32'(bus.act_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_valid", 32'(bus.act_valid), 32'd0);
    chk("mr_code", 32'(bus.act_code), 32'd0);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_pressed", 32'(bus.pressed), 32'd0);
    bus.buttons = 8'h00;
    bus.act_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    v0 = v_cnt;
    idle(30);
    chk("mr_no_reoffer", 32'(v_cnt - v0), 32'd0);

    // Button held through reset release counts as a new press.
    reset = 1'b1;
    bus.buttons = 8'h10;
    idle(2);
    reset = 1'b0;
    wait_valid(20, k);
    chk("hold_rst_latency", 32'(k), 32'd7);
    chk("hold_rst_code", 32'(bus.act_code), 32'd4);
    bus.buttons = 8'h00;
    idle(20);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
